// File: rtl/adc_serial_reader_if.sv
// Signal bundle between the ADC serial reader and its surroundings: ADC pins plus sample outputs.
// The master modport is the reader itself; the slave modport is the ADC/consumer side.
interface adc_serial_reader_if;
    logic        enable;
    logic        sdata;
    logic        cs_n;
    logic        sclk;
    logic [11:0] sample;
    logic        A;
    logic        B;
    logic        C;
    logic        D;
    logic        sample_valid;
    logic        frame_err;

    modport master (
        input  enable, sdata,
        output cs_n, sclk, sample, A, B, C, D, sample_valid, frame_err
    );

    modport slave (
        output enable, sdata,
        input  cs_n, sclk, sample, A, B, C, D, sample_valid, frame_err
    );
endinterface

// File: rtl/adc_serial_reader.sv
// SPI-style reader for a 12-bit AD7476-class ADC: 16-clock frames, 4 leading zeros, MSB first.
// Runs back-to-back conversions while enabled; every output is a flop.
module adc_serial_reader #(
    parameter int unsigned CLK_DIV    = 25,
    parameter int unsigned SAMPLE_GAP = 50
) (
    input logic                 clk,
    input logic                 reset_n,
    adc_serial_reader_if.master bus
);

    localparam int unsigned CntMax = (CLK_DIV > SAMPLE_GAP) ? CLK_DIV : SAMPLE_GAP;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] DivLast = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] GapLast = CntW'(SAMPLE_GAP - 1);

    typedef enum logic [2:0] {StIdle, StStart, StShift, StStop, StWait} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      bit_q, bit_d;
    logic            half_q, half_d;
    logic [15:0]     shift_q, shift_d;
    logic [11:0]     sample_q, sample_d;
    logic            cs_n_q, cs_n_d;
    logic            sclk_q, sclk_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        half_d   = half_q;
        shift_d  = shift_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.enable) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == DivLast) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    bit_d   = 4'd0;
                    half_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShift: begin
                if (cnt_q == DivLast) begin
                    cnt_d = '0;
                    if (!half_q) begin
                        // This edge raises sclk, so it is also the capture edge.
                        half_d  = 1'b1;
                        shift_d = {shift_q[14:0], bus.sdata};
                    end else if (bit_q == 4'd15) begin
                        state_d = StStop;
                        if (shift_q[15:12] == 4'b0000) begin
                            sample_d = shift_q[11:0];
                            valid_d  = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        bit_d  = bit_q + 4'd1;
                        half_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                state_d = StWait;
                cnt_d   = '0;
            end
            StWait: begin
                if (cnt_q == GapLast) begin
                    cnt_d   = '0;
                    state_d = bus.enable ? StStart : StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Pin levels follow the next state so they change on the same edge as the FSM.
        cs_n_d = !((state_d == StStart) || (state_d == StShift));
        sclk_d = !((state_d == StShift) && !half_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bit_q    <= 4'd0;
            half_q   <= 1'b0;
            shift_q  <= 16'd0;
            sample_q <= 12'd0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b1;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            half_q   <= half_d;
            shift_q  <= shift_d;
            sample_q <= sample_d;
            cs_n_q   <= cs_n_d;
            sclk_q   <= sclk_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign bus.cs_n         = cs_n_q;
    assign bus.sclk         = sclk_q;
    assign bus.sample       = sample_q;
    assign bus.A            = sample_q[11];
    assign bus.B            = sample_q[10];
    assign bus.C            = sample_q[9];
    assign bus.D            = sample_q[8];
    assign bus.sample_valid = valid_q;
    assign bus.frame_err    = err_q;

endmodule

// File: tb/tb_adc_serial_reader.sv
// Bench for adc_serial_reader: ADC models feed queued words, monitors score each strobe against
// expectations pushed by the stimulus, plus frame timing and reset checks.
module tb_adc_serial_reader;

    typedef struct packed {
        logic        err;
        logic [11:0] smp;
        logic [3:0]  abcd;
    } exp_t;

    logic clk;
    logic reset_n;

    adc_serial_reader_if sif0 ();
    adc_serial_reader_if sif1 ();

    adc_serial_reader #(.CLK_DIV(2), .SAMPLE_GAP(4)) u_dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (sif0)
    );

    adc_serial_reader #(.CLK_DIV(1), .SAMPLE_GAP(4)) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (sif1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    logic [15:0] wq0[$];
    logic [15:0] wq1[$];
    exp_t        exp0[$];
    exp_t        exp1[$];

    logic [15:0] cur0, cur1;
    exp_t        e0, e1;
    int lo0, r0, hi0, falls0, rises0, last_gap0;
    int lo1, r1, hi1, falls1, rises1;
    logic prev_cs0, prev_sclk0, prev_cs1, prev_sclk1;

    // ADC model + monitor for the CLK_DIV=2 instance
    always @(negedge clk) begin
        if (!reset_n) begin
            lo0 = 0; r0 = 0; prev_cs0 = 1'b1; prev_sclk0 = 1'b1; sif0.sdata = 1'b0;
        end else begin
            if (!sif0.cs_n && prev_cs0) begin
                falls0++;
                last_gap0 = hi0;
                cur0 = (wq0.size() > 0) ? wq0.pop_front() : 16'hFFFF;
                lo0 = 0;
                r0 = 0;
            end
            if (sif0.sclk && !prev_sclk0) begin
                rises0++;
                if (!sif0.cs_n) r0++;
            end
            if (!sif0.cs_n) begin
                lo0++;
                hi0 = 0;
            end else begin
                hi0++;
            end
            if (sif0.cs_n && !prev_cs0) begin
                check("cs_n low cycles (div2)", 32'(lo0), 32'd66);
                check("sclk rises (div2)", 32'(r0), 32'd16);
            end
            if (sif0.sample_valid || sif0.frame_err) begin
                check("strobe exclusive (div2)", 32'(sif0.sample_valid && sif0.frame_err), 32'd0);
                check("strobe at cs_n rise (div2)", 32'({sif0.cs_n, prev_cs0}), 32'b10);
                if (exp0.size() == 0) begin
                    check("unexpected strobe (div2)", 32'(sif0.frame_err), 32'hDEAD);
                end else begin
                    e0 = exp0.pop_front();
                    check("strobe kind (div2)", 32'(sif0.frame_err), 32'(e0.err));
                    check("sample (div2)", 32'(sif0.sample), 32'(e0.smp));
                    check("A..D (div2)", 32'({sif0.A, sif0.B, sif0.C, sif0.D}), 32'(e0.abcd));
                end
            end
            sif0.sdata = (!sif0.cs_n && r0 < 16) ? cur0[4'(15 - r0)] : 1'b0;
            prev_cs0 = sif0.cs_n;
            prev_sclk0 = sif0.sclk;
        end
    end

    // ADC model + monitor for the CLK_DIV=1 instance
    always @(negedge clk) begin
        if (!reset_n) begin
            lo1 = 0; r1 = 0; prev_cs1 = 1'b1; prev_sclk1 = 1'b1; sif1.sdata = 1'b0;
        end else begin
            if (!sif1.cs_n && prev_cs1) begin
                falls1++;
                cur1 = (wq1.size() > 0) ? wq1.pop_front() : 16'hFFFF;
                lo1 = 0;
                r1 = 0;
            end
            if (sif1.sclk && !prev_sclk1) begin
                rises1++;
                if (!sif1.cs_n) r1++;
            end
            if (!sif1.cs_n) begin
                lo1++;
                hi1 = 0;
            end else begin
                hi1++;
            end
            if (sif1.cs_n && !prev_cs1) begin
                check("cs_n low cycles (div1)", 32'(lo1), 32'd33);
                check("sclk rises (div1)", 32'(r1), 32'd16);
            end
            if (sif1.sample_valid || sif1.frame_err) begin
                check("strobe exclusive (div1)", 32'(sif1.sample_valid && sif1.frame_err), 32'd0);
                check("strobe at cs_n rise (div1)", 32'({sif1.cs_n, prev_cs1}), 32'b10);
                if (exp1.size() == 0) begin
                    check("unexpected strobe (div1)", 32'(sif1.frame_err), 32'hDEAD);
                end else begin
                    e1 = exp1.pop_front();
                    check("strobe kind (div1)", 32'(sif1.frame_err), 32'(e1.err));
                    check("sample (div1)", 32'(sif1.sample), 32'(e1.smp));
                    check("A..D (div1)", 32'({sif1.A, sif1.B, sif1.C, sif1.D}), 32'(e1.abcd));
                end
            end
            sif1.sdata = (!sif1.cs_n && r1 < 16) ? cur1[4'(15 - r1)] : 1'b0;
            prev_cs1 = sif1.cs_n;
            prev_sclk1 = sif1.sclk;
        end
    end

    task automatic push0(input logic [15:0] word, input logic err, input logic [11:0] smp,
                         input logic [3:0] abcd);
        exp_t x;
        x.err = err; x.smp = smp; x.abcd = abcd;
        wq0.push_back(word);
        exp0.push_back(x);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " cs_n"}, 32'(sif0.cs_n), 32'd1);
        check({tag, " sclk"}, 32'(sif0.sclk), 32'd1);
        check({tag, " sample"}, 32'(sif0.sample), 32'd0);
        check({tag, " A..D"}, 32'({sif0.A, sif0.B, sif0.C, sif0.D}), 32'd0);
        check({tag, " strobes"}, 32'({sif0.sample_valid, sif0.frame_err}), 32'd0);
    endtask

    int t, snap_rises, snap_falls;
    exp_t x1;

    initial begin
        falls0 = 0; rises0 = 0; hi0 = 0; last_gap0 = 0;
        falls1 = 0; rises1 = 0; hi1 = 0;
        reset_n = 1'b0;
        sif0.enable = 1'b0;
        sif1.enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset cs_n (div1)", 32'(sif1.cs_n), 32'd1);

        // Continuous run: clean, back-to-back, bad leading bits, then enable drop.
        push0(16'h0ABC, 1'b0, 12'hABC, 4'b1010);
        push0(16'h0F00, 1'b0, 12'hF00, 4'b1111);
        push0(16'h0123, 1'b0, 12'h123, 4'b0001);
        push0(16'h0800, 1'b0, 12'h800, 4'b1000);
        push0(16'h8FFF, 1'b1, 12'h800, 4'b1000);
        push0(16'h0555, 1'b0, 12'h555, 4'b0101);
        reset_n = 1'b1;
        @(posedge clk);
        #1 sif0.enable = 1'b1;

        t = 0;
        while (falls0 < 2 && t < 2000) begin @(posedge clk); t++; end
        check("wait second frame", 32'(falls0 >= 2), 32'd1);
        check("frame gap 1->2", 32'(last_gap0), 32'd5);
        t = 0;
        while (falls0 < 3 && t < 2000) begin @(posedge clk); t++; end
        check("frame gap 2->3", 32'(last_gap0), 32'd5);

        t = 0;
        while (falls0 < 6 && t < 2000) begin @(posedge clk); t++; end
        check("wait sixth frame", 32'(falls0 >= 6), 32'd1);
        repeat (10) @(posedge clk);
        #1 sif0.enable = 1'b0;
        t = 0;
        while (exp0.size() > 0 && t < 2000) begin @(posedge clk); t++; end
        check("expected strobes drained", 32'(exp0.size()), 32'd0);

        repeat (20) @(posedge clk);
        snap_rises = rises0;
        snap_falls = falls0;
        repeat (50) @(posedge clk);
        #1;
        check("idle: no sclk rises", 32'(rises0 - snap_rises), 32'd0);
        check("idle: no cs_n falls", 32'(falls0 - snap_falls), 32'd0);
        check("idle: cs_n high", 32'(sif0.cs_n), 32'd1);

        // Abort a frame with reset during the 8th sclk period.
        wq0.push_back(16'h0777);
        snap_falls = falls0;
        sif0.enable = 1'b1;
        t = 0;
        while (!(falls0 > snap_falls && r0 == 7 && !sif0.sclk) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("reached 8th sclk period", 32'(r0), 32'd7);
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("mid-frame reset");
        repeat (3) @(posedge clk);
        push0(16'h0321, 1'b0, 12'h321, 4'b0011);
        snap_falls = falls0;
        #1 reset_n = 1'b1;
        t = 0;
        while (falls0 == snap_falls && t < 2000) begin @(posedge clk); t++; end
        #1 sif0.enable = 1'b0;
        t = 0;
        while (exp0.size() > 0 && t < 2000) begin @(posedge clk); t++; end
        check("post-reset frame strobe", 32'(exp0.size()), 32'd0);

        // CLK_DIV=1 corner.
        x1.err = 1'b0; x1.smp = 12'hFFF; x1.abcd = 4'b1111;
        wq1.push_back(16'h0FFF);
        exp1.push_back(x1);
        sif1.enable = 1'b1;
        t = 0;
        while (falls1 < 1 && t < 2000) begin @(posedge clk); t++; end
        #1 sif1.enable = 1'b0;
        t = 0;
        while (exp1.size() > 0 && t < 2000) begin @(posedge clk); t++; end
        check("div1 strobe seen", 32'(exp1.size()), 32'd0);

        repeat (20) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
